// File: rtl/alu_disp_pkg.sv
// rtl/alu_disp_pkg.sv - shared types and constants for the ALU result BCD display
// Purpose: FSM state type, 7-segment glyph table, digit-select one-hot codes and
//          one double-dabble iteration helper.
// Ports: none (package).
package alu_disp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_e;

    // Glyphs as {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_LUT [0:9] = '{
        7'b0111111,  // 0
        7'b0000110,  // 1
        7'b1011011,  // 2
        7'b1001111,  // 3
        7'b1100110,  // 4
        7'b1101101,  // 5
        7'b1111101,  // 6
        7'b0000111,  // 7
        7'b1111111,  // 8
        7'b1101111   // 9
    };

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [2:0] DIG_HUND = 3'b100;
    localparam logic [2:0] DIG_TENS = 3'b010;
    localparam logic [2:0] DIG_ONES = 3'b001;

    // One double-dabble iteration on {hund,tens,ones,binary}: every BCD nibble
    // that is 5 or more gets +3, then the whole register shifts left by one.
    function automatic logic [19:0] dd_step(input logic [19:0] r);
        logic [19:0] a;
        a = r;
        if (a[11:8]  >= 4'd5) a[11:8]  = a[11:8]  + 4'd3;
        if (a[15:12] >= 4'd5) a[15:12] = a[15:12] + 4'd3;
        if (a[19:16] >= 4'd5) a[19:16] = a[19:16] + 4'd3;
        return {a[18:0], 1'b0};
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD nibble to 7-segment decoder with blanking
// Purpose: maps a 0..9 nibble to its glyph; blank request or 10..15 give all-off.
// Ports:
//   nibble_i  in  4  BCD digit
//   blank_i   in  1  force all segments off
//   seg_o     out 7  segments {g,f,e,d,c,b,a}, active-high
module bcd_to_seg7
    import alu_disp_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i && (nibble_i <= 4'd9)) begin
            seg_o = SEG_LUT[nibble_i];
        end
    end

endmodule

// File: rtl/alu_result_bcd_display.sv
// rtl/alu_result_bcd_display.sv - 8-bit result to 3-digit BCD with muxed 7-segment drive
// Purpose: accepts an ALU result with a valid/ready handshake, converts it to BCD
//          in 8 cycles with a sequential double-dabble engine, and scans the three
//          digits onto a shared 7-segment bus.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   res_valid/ready    result handshake, res_data 8-bit unsigned result
//   bcd_done           one-cycle pulse when new digits land
//   bcd_hund/tens/ones converted digits
//   seg, dig_sel       registered segment pattern and one-hot digit enable
module alu_result_bcd_display
    import alu_disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 1000,
    parameter bit          BLANK_LZ    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       res_valid,
    input  logic [7:0] res_data,
    output logic       res_ready,
    output logic       bcd_done,
    output logic [3:0] bcd_hund,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic [6:0] seg,
    output logic [2:0] dig_sel
);

    localparam logic [15:0] PRE_LAST = 16'(REFRESH_DIV - 1);

    state_e      state_q;
    logic [19:0] shreg_q;
    logic [2:0]  cnt_q;
    logic        ready_q;
    logic        done_q;
    logic [3:0]  hund_q, tens_q, ones_q;

    logic [19:0] step;
    logic        conv_last;
    logic [3:0]  hund_d, tens_d, ones_d;

    assign step      = dd_step(shreg_q);
    assign conv_last = (state_q == CONV) && (cnt_q == 3'd7);

    // Next digit values are exposed so the display can decode them in the same
    // edge the digit registers update.
    assign hund_d = conv_last ? step[19:16] : hund_q;
    assign tens_d = conv_last ? step[15:12] : tens_q;
    assign ones_d = conv_last ? step[11:8]  : ones_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= 20'd0;
            cnt_q   <= 3'd0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            hund_q  <= 4'd0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (res_valid && ready_q) begin
                        shreg_q <= {12'd0, res_data};
                        cnt_q   <= 3'd0;
                        ready_q <= 1'b0;
                        state_q <= CONV;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                CONV: begin
                    shreg_q <= step;
                    cnt_q   <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        hund_q  <= hund_d;
                        tens_q  <= tens_d;
                        ones_q  <= ones_d;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Display scan
    logic [15:0] pre_q, pre_d;
    logic [2:0]  sel_q, sel_d;
    logic [6:0]  seg_q, seg_d;
    logic [3:0]  mux_nib;
    logic        mux_blank;

    always_comb begin
        pre_d = pre_q + 16'd1;
        sel_d = sel_q;
        if (pre_q == PRE_LAST) begin
            pre_d = 16'd0;
            sel_d = {sel_q[1:0], sel_q[2]};
        end
    end

    // Select the digit that will be enabled after this edge so seg and dig_sel
    // always move together.
    always_comb begin
        mux_nib   = ones_d;
        mux_blank = 1'b0;
        case (sel_d)
            DIG_HUND: begin
                mux_nib   = hund_d;
                mux_blank = BLANK_LZ && (hund_d == 4'd0);
            end
            DIG_TENS: begin
                mux_nib   = tens_d;
                mux_blank = BLANK_LZ && (hund_d == 4'd0) && (tens_d == 4'd0);
            end
            default: begin
                mux_nib   = ones_d;
                mux_blank = 1'b0;
            end
        endcase
    end

    bcd_to_seg7 u_dec (
        .nibble_i (mux_nib),
        .blank_i  (mux_blank),
        .seg_o    (seg_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= 16'd0;
            sel_q <= DIG_ONES;
            seg_q <= SEG_LUT[0];
        end else begin
            pre_q <= pre_d;
            sel_q <= sel_d;
            seg_q <= seg_d;
        end
    end

    assign res_ready = ready_q;
    assign bcd_done  = done_q;
    assign bcd_hund  = hund_q;
    assign bcd_tens  = tens_q;
    assign bcd_ones  = ones_q;
    assign seg       = seg_q;
    assign dig_sel   = sel_q;

endmodule

// File: tb/tb_alu_result_bcd_display.sv
// tb/tb_alu_result_bcd_display.sv - self-checking bench for alu_result_bcd_display
module tb_alu_result_bcd_display;

    localparam int DIV = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n     = 1'b0;
    logic       res_valid = 1'b0;
    logic [7:0] res_data  = 8'd0;

    logic       ready0, done0, ready1, done1;
    logic [3:0] hund0, tens0, ones0, hund1, tens1, ones1;
    logic [6:0] seg0, seg1;
    logic [2:0] sel0, sel1;

    alu_result_bcd_display #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .res_valid(res_valid), .res_data(res_data),
        .res_ready(ready0), .bcd_done(done0), .bcd_hund(hund0), .bcd_tens(tens0),
        .bcd_ones(ones0), .seg(seg0), .dig_sel(sel0)
    );

    alu_result_bcd_display #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .res_valid(res_valid), .res_data(res_data),
        .res_ready(ready1), .bcd_done(done1), .bcd_hund(hund1), .bcd_tens(tens1),
        .bcd_ones(ones1), .seg(seg1), .dig_sel(sel1)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [6:0] glyph [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    function automatic logic [6:0] exp_seg(input bit blank, input int d,
                                           input int h, input int t, input int o);
        if (d == 2) return (blank && h == 0) ? 7'h00 : glyph[h];
        if (d == 1) return (blank && h == 0 && t == 0) ? 7'h00 : glyph[t];
        return glyph[o];
    endfunction

    // Behavioural model: a result accepted at an edge appears as decimal digits
    // eight edges later; the scanned digit is (cycles since reset / DIV) mod 3.
    bit m_ready, m_done;
    int m_busy, m_val, m_h, m_t, m_o, m_cyc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready <= 1'b0; m_done <= 1'b0; m_busy <= 0;
            m_h <= 0; m_t <= 0; m_o <= 0; m_cyc <= 0;
        end else begin
            m_done <= 1'b0;
            m_cyc  <= m_cyc + 1;
            if (m_busy != 0) begin
                m_busy <= m_busy - 1;
                if (m_busy == 1) begin
                    m_h <= m_val / 100;
                    m_t <= (m_val / 10) % 10;
                    m_o <= m_val % 10;
                    m_done  <= 1'b1;
                    m_ready <= 1'b1;
                end
            end else if (m_ready && res_valid) begin
                m_val   <= int'(res_data);
                m_busy  <= 8;
                m_ready <= 1'b0;
            end else begin
                m_ready <= 1'b1;
            end
        end
    end

    function automatic int cur_digit();
        return (m_cyc / DIV) % 3;
    endfunction

    bit cmp_en = 1'b0;
    int tcyc = 0;
    int done_t[$];

    always @(posedge clk) tcyc <= tcyc + 1;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("ready0", ready0, m_ready);
            check("ready1", ready1, m_ready);
            check("done0", done0, m_done);
            check("done1", done1, m_done);
            check("hund0", hund0, m_h);
            check("tens0", tens0, m_t);
            check("ones0", ones0, m_o);
            check("hund1", hund1, m_h);
            check("tens1", tens1, m_t);
            check("ones1", ones1, m_o);
            check("dig_sel0", sel0, 3'b001 << cur_digit());
            check("dig_sel1", sel1, 3'b001 << cur_digit());
            check("seg0", seg0, exp_seg(1'b1, cur_digit(), m_h, m_t, m_o));
            check("seg1", seg1, exp_seg(1'b0, cur_digit(), m_h, m_t, m_o));
            if (done0) done_t.push_back(tcyc);
        end
    end

    task automatic send(input logic [7:0] v);
        bit ok;
        ok = 1'b0;
        @(negedge clk); #1;
        res_valid = 1'b1;
        res_data  = v;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk); #1;
            if (m_busy == 8) ok = 1'b1;
        end
        res_valid = 1'b0;
        res_data  = 8'($urandom);
        check("accept", ok, 1'b1);
    endtask

    // Called right after the accept edge; checks digits eight edges later.
    task automatic expect_result(input int h, input int t, input int o);
        repeat (8) @(posedge clk);
        #1;
        check("lit_done", done0, 1'b1);
        check("lit_hund", hund0, h);
        check("lit_tens", tens0, t);
        check("lit_ones", ones0, o);
        @(posedge clk); #1;
        check("lit_done_pulse", done0, 1'b0);
    endtask

    task automatic wait_digit(input int d);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (cur_digit() == d) ok = 1'b1;
        end
        check("wait_digit", ok, 1'b1);
    endtask

    task automatic check_reset_outputs();
        check("rst_ready", ready0, 1'b0);
        check("rst_done", done0, 1'b0);
        check("rst_hund", hund0, 4'd0);
        check("rst_tens", tens0, 4'd0);
        check("rst_ones", ones0, 4'd0);
        check("rst_sel", sel0, 3'b001);
        check("rst_seg", seg0, 7'b0111111);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        int n0;
        bit ok;

        // Reset and release
        repeat (3) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        check_reset_outputs();
        @(negedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", ready0, 1'b0);
        @(posedge clk); #1;
        check("ready_after_edge", ready0, 1'b1);

        // Conversions
        send(8'd255); expect_result(2, 5, 5);
        send(8'd0);   expect_result(0, 0, 0);
        send(8'd100); expect_result(1, 0, 0);

        // Back-to-back with res_valid held; data changes mid-conversion
        n0 = done_t.size();
        @(negedge clk); #1;
        res_valid = 1'b1;
        res_data  = 8'd37;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk); #1;
            if (m_busy == 8) ok = 1'b1;
        end
        check("hs_accept1", ok, 1'b1);
        res_data = 8'd142;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk); #1;
            if (m_busy == 8) ok = 1'b1;
        end
        check("hs_accept2", ok, 1'b1);
        res_valid = 1'b0;
        check("hs_hund_a", hund0, 4'd0);
        check("hs_tens_a", tens0, 4'd3);
        check("hs_ones_a", ones0, 4'd7);
        expect_result(1, 4, 2);
        repeat (4) @(posedge clk);
        #1;
        check("hs_pulses", done_t.size() - n0, 2);
        if (done_t.size() - n0 == 2)
            check("hs_spacing", done_t[n0 + 1] - done_t[n0], 9);

        // Leading-zero blanking
        send(8'd7); expect_result(0, 0, 7);
        wait_digit(2);
        check("blank_h0", seg0, 7'h00);
        check("blank_h1", seg1, 7'b0111111);
        wait_digit(1);
        check("blank_t0", seg0, 7'h00);
        check("blank_t1", seg1, 7'b0111111);
        wait_digit(0);
        check("blank_o0", seg0, 7'b0000111);
        check("blank_o1", seg1, 7'b0000111);

        // Scan order
        send(8'd123); expect_result(1, 2, 3);
        repeat (12) @(negedge clk);
        wait_digit(0);
        check("mux_sel_o", sel0, 3'b001);
        check("mux_seg_o", seg0, 7'b1001111);
        wait_digit(1);
        check("mux_sel_t", sel0, 3'b010);
        check("mux_seg_t", seg0, 7'b1011011);
        wait_digit(2);
        check("mux_sel_h", sel0, 3'b100);
        check("mux_seg_h", seg0, 7'b0000110);

        // Abort by reset mid-conversion
        n0 = done_t.size();
        send(8'd200);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("abort_no_done", done_t.size() - n0, 0);
        check("abort_hund", hund0, 4'd0);
        check("abort_ones", ones0, 4'd0);
        send(8'd200); expect_result(2, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
